// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter and its session controller.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } sess_state_e;

    localparam int N_REQ_DEF = 4;

    // True when exactly one of the low 'width' bits of vec is set (width <= 32).
    function automatic logic onehot_valid(input logic [31:0] vec, input int width);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                cnt += int'(vec[i]);
            end
        end
        return (cnt == 1);
    endfunction

endpackage

// File: rtl/onehot_to_idx.sv
// Converts a one-hot vector to its bit index and flags whether it really is one-hot.
module onehot_to_idx
    import arb_pkg::*;
#(
    parameter  int N    = N_REQ_DEF,
    localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  onehot_i,
    output logic [IW-1:0] idx_o,
    output logic          is_onehot_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

    assign is_onehot_o = onehot_valid(32'(onehot_i), N);

endmodule

// File: rtl/arb_session_ctrl.sv
// Session controller behind the round-robin arbiter: latches a grant, routes the chosen
// requester stream to the slave, and ends the session on last beat, beat limit or timeout.
module arb_session_ctrl
    import arb_pkg::*;
#(
    parameter  int N         = N_REQ_DEF,
    parameter  int DATA_W    = 32,
    parameter  int MAX_BEATS = 8,
    parameter  int TIMEOUT   = 16,
    localparam int IDX_W     = (N > 1) ? $clog2(N) : 1,
    localparam int BEAT_W    = $clog2(MAX_BEATS + 1),
    localparam int IDLE_W    = $clog2(TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                rst_an,
    input  logic [N-1:0]        grant,
    output logic                session_is_finished,
    input  logic [N*DATA_W-1:0] s_data,
    input  logic [N-1:0]        s_valid,
    input  logic [N-1:0]        s_last,
    output logic [N-1:0]        s_ready,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_valid,
    output logic                m_last,
    output logic [IDX_W-1:0]    m_id,
    input  logic                m_ready,
    output logic                err_timeout,
    output logic                err_multi_grant,
    output sess_state_e         dbg_state
);

    // Handshake rule on both sides: a beat moves in a cycle where valid and ready are
    // both high; valid never waits on ready, and ready here is m_ready passed through.

    sess_state_e        state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;

    logic [IDX_W-1:0]   grant_idx;
    logic               grant_onehot;
    logic               sel_valid;
    logic               sel_last;
    logic [DATA_W-1:0]  sel_data;
    logic               handshake;
    logic               beat_at_limit;

    onehot_to_idx #(.N(N)) u_grant_idx (
        .onehot_i    (grant),
        .idx_o       (grant_idx),
        .is_onehot_o (grant_onehot)
    );

    assign sel_valid     = s_valid[sel_q];
    assign sel_last      = s_last[sel_q];
    assign sel_data      = s_data[int'(sel_q)*DATA_W +: DATA_W];
    assign beat_at_limit = (beat_cnt_q == BEAT_W'(MAX_BEATS - 1));
    assign m_id          = sel_q;
    assign dbg_state     = state_q;

    always_comb begin
        state_d             = state_q;
        sel_d               = sel_q;
        beat_cnt_d          = beat_cnt_q;
        idle_cnt_d          = idle_cnt_q;
        m_valid             = 1'b0;
        m_last              = 1'b0;
        m_data              = '0;
        s_ready             = '0;
        handshake           = 1'b0;
        session_is_finished = 1'b0;
        err_timeout         = 1'b0;
        err_multi_grant     = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_onehot) begin
                    sel_d      = grant_idx;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                    state_d    = ACTIVE;
                end else if (grant != '0) begin
                    err_multi_grant = 1'b1;
                end
            end

            ACTIVE: begin
                m_valid        = sel_valid;
                m_data         = sel_data;
                s_ready[sel_q] = m_ready;
                m_last         = sel_valid & (sel_last | beat_at_limit);
                handshake      = sel_valid & m_ready;

                if (handshake && (beat_cnt_q != BEAT_W'(MAX_BEATS))) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end

                // A stalled slave is not idle time; only a missing source beat counts.
                if (sel_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q >= IDLE_W'(TIMEOUT - 1)) begin
                    err_timeout = 1'b1;
                    state_d     = DONE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end

                if (handshake && m_last) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                session_is_finished = 1'b1;
                state_d             = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

endmodule
